pwm_gen: RTL
============

# pwm_gen

PWM waveform generator that consumes the single-cycle base `tick` produced by the PWM frequency divider and turns it into a duty-controlled output. Each period is `STEPS` ticks long. Duty updates arrive from the UART command decoder over a valid/ready handshake. Updates are double-buffered so that a new duty takes effect only at a period boundary, which prevents glitched or truncated pulses.

## Interface
- `STEPS`, default 100: ticks per PWM period; duty is in units of 1/STEPS.
- `DUTY_W`, default 7: width of the duty field; must satisfy 2^DUTY_W > STEPS.
- `DT_CYCLES`, default 4: dead-time length in `clk` cycles. Used only when the macro in Configuration is defined.

Ports:
- `clk` input 1: system clock (50 MHz).
- `rst` input 1: reset, asynchronous, active-high.
- `tick` input 1: single-cycle enable pulse from the frequency divider.
- `en` input 1: run request. Sampled only in IDLE and at period boundaries.
- `duty_in` input DUTY_W: requested duty, 0..STEPS. Values above STEPS are clamped to STEPS.
- `duty_valid` input 1: `duty_in` is valid.
- `duty_ready` output 1: the pending slot is empty; a transfer occurs when valid && ready.
- `pwm_out` output 1: PWM output (high side).
- `pwm_n` output 1: complementary output (low side).
- `period_start` output 1: one-cycle pulse when a new period begins.
- `busy` output 1: high while in RUN.

## Operation
- **Registers**
  - `step` (0..STEPS-1).
  - `active_duty`: the duty in use for the current period.
  - `pending_duty` and `pending_full`.
  - `raw`: the undelayed PWM level.
  - `state` ∈ {IDLE, RUN}.
- **Handshake**
  - `duty_ready = !pending_full`.
  - On a transfer: `pending_duty <= min(duty_in, STEPS)` and `pending_full <= 1`.
  - A pending value is consumed (`pending_full <= 0`) at the next period load.
  - Transfer and consume never occur in the same cycle, because ready is low while the slot is full.
- **Period load**
  - If `pending_full`: `active_duty <= pending_duty`. Otherwise `active_duty` is kept.
  - `step <= 0`.
  - `raw <= (loaded duty > 0)`.
  - `period_start <= 1` for one cycle.
- **IDLE**
  - `raw = 0`, `step = 0`.
  - On `tick && en`: perform a period load and go to RUN.
  - Without `tick`, `en` has no effect.
- **RUN**, on each `tick`:
  - If `step == STEPS-1` (boundary):
    - If `en == 1`: perform a period load and stay in RUN.
    - If `en == 0`: set `raw <= 0`, `step <= 0`, and go to IDLE.
  - Otherwise: `step <= step+1` and `raw <= (step+1 < active_duty)`.
- **Mid-period `en` drop**: the current period always completes. There is no truncation.
- **Duty extremes**
  - Duty 0 gives `raw` constantly 0 across the period.
  - Duty STEPS gives `raw` constantly 1, with no low gap between consecutive periods.
- **Outputs without the Configuration macro**: `pwm_out = raw` and `pwm_n = 0`.
- `busy = (state == RUN)`.

## Timing
- Reset values:
  - `pwm_out = 0`, `pwm_n = 0`, `period_start = 0`, `busy = 0`, `duty_ready = 1`.
  - `active_duty = 0`, `pending_full = 0`, state IDLE.
- All outputs are registered. `raw` and `period_start` update on the `clk` edge that samples `tick` high, so they are visible 1 cycle after the tick.
- Each period lasts exactly STEPS ticks. The high time is exactly `active_duty` ticks, counted tick-to-tick.
- Duty latency: a value accepted during period N applies at the start of period N+1. If it is accepted in the same cycle as a boundary tick, it is not loaded and applies at period N+2.
- Reset asserted mid-period: all outputs go low immediately (asynchronous reset), and a pending duty is discarded.
- `tick` is never assumed periodic. Between ticks all state holds.

## Configuration
- `PWM_DEADTIME_EN`, when defined, compiles in complementary outputs with dead-time:
  - When `raw` rises: `pwm_n` falls on the same cycle; `pwm_out` rises after DT_CYCLES `clk` cycles.
  - When `raw` falls: `pwm_out` falls on the same cycle; `pwm_n` rises after DT_CYCLES cycles.
  - A `raw` edge during an unfinished dead-time restarts the counter. Pulses shorter than DT_CYCLES are suppressed.
  - `pwm_out` and `pwm_n` are never high simultaneously.
  - In IDLE both outputs are 0.
  - Everything else is unchanged.
- Undefined: the dead-time counter is absent, `pwm_out = raw`, and `pwm_n` is tied to 0.

## Test plan
- Reset, then `en=1`, duty 25 accepted, `tick` every 10 clks:
  - The first period is the IDLE start load, where `pending_full` is set, so its duty is 25.
  - Expect `pwm_out` high for 25 ticks out of 100, and `period_start` once per 100 ticks.
- Running at duty 25, send duty 75 mid-period:
  - `duty_ready` drops for 1+ cycles.
  - The current period stays at 25; the next is 75.
  - A second transfer is refused until the boundary.
- Duty 0 and duty 100 (plus `duty_in=120`, which clamps to 100): `pwm_out` is constant 0, then constant 1 with no gap across boundaries.
- Drop `en` at step 40 of a duty-60 period: the period finishes with high time 60, then IDLE with `busy=0` and `pwm_out=0`.
- Assert `rst` at step 30 with `pending_full=1`: outputs go to 0 asynchronously and `duty_ready=1` after release.
- With `PWM_DEADTIME_EN`, `DT_CYCLES=4`, duty 50:
  - `pwm_out` rises 4 clks after `pwm_n` falls.
  - `pwm_n` rises 4 clks after `pwm_out` falls.
  - There is never overlap.

Source files
------------

// File: rtl/pwm_gen_if.sv
// Duty-update handshake between the command decoder (master) and pwm_gen (slave).
interface pwm_gen_if #(
    parameter int DUTY_W = 7
);
    logic [DUTY_W-1:0] duty_in;
    logic              duty_valid;
    logic              duty_ready;

    modport master (output duty_in, output duty_valid, input duty_ready);
    modport slave  (input duty_in, input duty_valid, output duty_ready);
endinterface

// File: rtl/pwm_gen.sv
// Tick-driven PWM generator with double-buffered duty updates applied at period boundaries.
// Optional dead-time complementary outputs are compiled in with `define PWM_DEADTIME_EN.
module pwm_gen #(
    parameter int STEPS     = 100,
    parameter int DUTY_W    = 7,
    parameter int DT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       en,
    pwm_gen_if.slave   duty_if,
    output logic       pwm_out,
    output logic       pwm_n,
    output logic       period_start,
    output logic       busy
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] step_q, step_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic [DUTY_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic              raw_q, raw_d;
    logic              ps_q, ps_d;
    logic              boundary, load, xfer;
    logic [DUTY_W-1:0] load_duty;

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_W'(STEPS)) ? DUTY_W'(STEPS) : d;
    endfunction

    assign boundary  = (step_q == DUTY_W'(STEPS - 1));
    assign xfer      = duty_if.duty_valid && !pend_full_q;
    assign load      = tick && en && ((state_q == IDLE) || boundary);
    assign load_duty = pend_full_q ? pend_q : active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && en) state_d = RUN;
            RUN:     if (tick && boundary && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Xfer only happens while the slot is empty, so it never collides with a consume.
    always_comb begin
        step_d      = step_q;
        raw_d       = raw_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        ps_d        = 1'b0;
        if (load) begin
            active_d    = load_duty;
            step_d      = '0;
            raw_d       = (load_duty != '0);
            ps_d        = 1'b1;
            pend_full_d = 1'b0;
        end else if (tick && (state_q == RUN)) begin
            if (boundary) begin
                step_d = '0;
                raw_d  = 1'b0;
            end else begin
                step_d = step_q + DUTY_W'(1);
                raw_d  = ((step_q + DUTY_W'(1)) < active_q);
            end
        end
        if (xfer) begin
            pend_d      = sat_duty(duty_if.duty_in);
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q      <= '0;
            active_q    <= '0;
            pend_full_q <= 1'b0;
            raw_q       <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            step_q      <= step_d;
            active_q    <= active_d;
            pend_full_q <= pend_full_d;
            raw_q       <= raw_d;
            ps_q        <= ps_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign duty_if.duty_ready = !pend_full_q;
    assign period_start       = ps_q;
    assign busy               = (state_q == RUN);

`ifdef PWM_DEADTIME_EN
    localparam int CNT_W = $clog2(DT_CYCLES + 1);

    logic [CNT_W-1:0] dt_cnt_q, dt_cnt_d;
    logic             hi_tgt_q, hi_tgt_d, lo_tgt_q, lo_tgt_d;
    logic             out_q, out_d, n_q, n_d;

    // Any change of the wanted high/low pair blanks both sides and restarts the dead-time.
    always_comb begin
        hi_tgt_d = raw_d;
        lo_tgt_d = !raw_d && (state_d == RUN);
        if ((hi_tgt_d != hi_tgt_q) || (lo_tgt_d != lo_tgt_q))
            dt_cnt_d = CNT_W'(DT_CYCLES);
        else if (dt_cnt_q != '0)
            dt_cnt_d = dt_cnt_q - CNT_W'(1);
        else
            dt_cnt_d = dt_cnt_q;
        out_d = (dt_cnt_d == '0) && hi_tgt_d;
        n_d   = (dt_cnt_d == '0) && lo_tgt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_cnt_q <= '0;
            hi_tgt_q <= 1'b0;
            lo_tgt_q <= 1'b0;
            out_q    <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            dt_cnt_q <= dt_cnt_d;
            hi_tgt_q <= hi_tgt_d;
            lo_tgt_q <= lo_tgt_d;
            out_q    <= out_d;
            n_q      <= n_d;
        end
    end

    assign pwm_out = out_q;
    assign pwm_n   = n_q;
`else
    assign pwm_out = raw_q;
    assign pwm_n   = 1'b0;

    // Dead-time length is meaningless without the complementary stage.
    if (DT_CYCLES < 0) begin : g_dt_unused
    end
`endif

endmodule
